// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: debounce a 7-segment bus and decode it back to a hex digit, flagging blank and illegal patterns.
module seven_seg_decoder #(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  input  logic             err_clr,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             new_digit,
  output logic             blank,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);
  localparam logic [6:0] OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  typedef enum logic [1:0] {IDLE, SETTLING, LOCKED} state_t;
  state_t           state_q, state_d;
  logic [6:0]       sync1_q, sync2_q, pat, cand_q, cand_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       dec_val, digit_q, digit_d;
  logic             dec_legal, is_blank, illegal, accept;
  logic             valid_q, valid_d, blank_q, blank_d, new_q, new_d, err_q, err_d;
  logic [ERR_W-1:0] ecnt_q, ecnt_d;
  assign pat      = ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign is_blank = cand_q == 7'h00;
  assign illegal  = !dec_legal && !is_blank;
  always_comb begin
    dec_legal = 1'b1;
    dec_val   = 4'h0;
    case (cand_q)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
      default: dec_legal = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        cand_d  = pat;
        cnt_d   = 8'd1;
        state_d = SETTLING;
      end
      SETTLING: begin
        if (pat != cand_q) begin
          cand_d = pat;
          cnt_d  = 8'd1;
        end else if (cnt_q == 8'(STABLE_CYCLES)) begin
          accept  = 1'b1;
          state_d = LOCKED;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        if (pat != cand_q) begin
          cand_d  = pat;
          cnt_d   = 8'd1;
          state_d = SETTLING;
        end
      end
    endcase
  end
  // Re-accepting the digit already shown (e.g. after a glitch) is not a new digit.
  assign digit_d = accept && dec_legal ? dec_val : digit_q;
  assign valid_d = accept ? dec_legal : valid_q;
  assign blank_d = accept ? is_blank : blank_q;
  assign new_d   = accept && dec_legal && (!valid_q || dec_val != digit_q);
  assign err_d   = accept && illegal;
  assign ecnt_d  = err_clr ? '0 : (err_d && ecnt_q != '1) ? ecnt_q + ERR_W'(1) : ecnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= OFF;
      sync2_q <= OFF;
      state_q <= IDLE;
      cand_q  <= 7'h00;
      cnt_q   <= 8'd0;
      digit_q <= 4'h0;
      valid_q <= 1'b0;
      blank_q <= 1'b0;
      new_q   <= 1'b0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      sync1_q <= seg_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      new_q   <= new_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end
  assign digit_out   = digit_q;
  assign digit_valid = valid_q;
  assign blank       = blank_q;
  assign new_digit   = new_q;
  assign err         = err_q;
  assign err_count   = ecnt_q;
endmodule

// File: tb/tb_seven_seg_decoder.sv
// tb_seven_seg_decoder: table-driven scoreboard bench for an active-low/4-cycle decoder and an active-high/1-cycle one.
module tb_seven_seg_decoder;
  typedef struct {
    logic [6:0] pat;
    logic [3:0] d;
    logic       v, b, nd, e;
    logic [1:0] ec;
    logic       clr;
  } vec_t;
  logic       clk = 1'b0, rst = 1'b1, err_clr_a = 1'b0, err_clr_b = 1'b0;
  logic [6:0] seg_a = 7'h7F, seg_b = 7'h00;
  logic [3:0] digit_a, digit_b;
  logic       valid_a, nd_a, blank_a, err_a, valid_b, nd_b, blank_b, err_b;
  logic [1:0] ecnt_a;
  logic [7:0] ecnt_b;
  int         checks = 0, errors = 0;
  vec_t       tbl[24];
  vec_t       sbq[$];
  vec_t       prev, got;
  always #5 clk = ~clk;
  seven_seg_decoder #(.ACTIVE_LOW(1'b1), .STABLE_CYCLES(4), .ERR_W(2)) u_a (
    .clk(clk), .rst(rst), .seg_in(seg_a), .err_clr(err_clr_a), .digit_out(digit_a),
    .digit_valid(valid_a), .new_digit(nd_a), .blank(blank_a), .err(err_a), .err_count(ecnt_a));
  seven_seg_decoder #(.ACTIVE_LOW(1'b0), .STABLE_CYCLES(1), .ERR_W(8)) u_b (
    .clk(clk), .rst(rst), .seg_in(seg_b), .err_clr(err_clr_b), .digit_out(digit_b),
    .digit_valid(valid_b), .new_digit(nd_b), .blank(blank_b), .err(err_b), .err_count(ecnt_b));
  function automatic vec_t mk(input logic [6:0] p, input logic [3:0] d, input logic v, b, nd, e,
                              input logic [1:0] ec, input logic clr);
    vec_t x;
    x.pat = p; x.d = d; x.v = v; x.b = b; x.nd = nd; x.e = e; x.ec = ec; x.clr = clr;
    return x;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic apply(input vec_t x, input string nm);
    seg_a = ~x.pat;
    sbq.push_back(x);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk({nm, "_hold"}, {digit_a, valid_a, blank_a, nd_a, err_a}, {prev.d, prev.v, prev.b, 2'b00});
    end
    if (x.clr) err_clr_a = 1'b1;
    tick;
    err_clr_a = 1'b0;
    got = sbq.pop_front();
    chk({nm, "_out"}, {digit_a, valid_a, blank_a, nd_a, err_a}, {got.d, got.v, got.b, got.nd, got.e});
    chk({nm, "_cnt"}, ecnt_a, got.ec);
    tick;
    chk({nm, "_pulse_end"}, {nd_a, err_a}, 2'b00);
    prev = got;
  endtask
  initial begin
    tbl[0]  = mk(7'h5B, 4'h2, 1, 0, 1, 0, 2'd0, 0);
    tbl[1]  = mk(7'h07, 4'h7, 1, 0, 1, 0, 2'd0, 0);
    tbl[2]  = mk(7'h6D, 4'h5, 1, 0, 1, 0, 2'd0, 0);
    tbl[3]  = mk(7'h00, 4'h5, 0, 1, 0, 0, 2'd0, 0);
    tbl[4]  = mk(7'h6D, 4'h5, 1, 0, 1, 0, 2'd0, 0);
    tbl[5]  = mk(7'h01, 4'h5, 0, 0, 0, 1, 2'd1, 0);
    tbl[6]  = mk(7'h00, 4'h5, 0, 1, 0, 0, 2'd1, 0);
    tbl[7]  = mk(7'h01, 4'h5, 0, 0, 0, 1, 2'd2, 0);
    tbl[8]  = mk(7'h00, 4'h5, 0, 1, 0, 0, 2'd2, 0);
    tbl[9]  = mk(7'h01, 4'h5, 0, 0, 0, 1, 2'd3, 0);
    tbl[10] = mk(7'h00, 4'h5, 0, 1, 0, 0, 2'd3, 0);
    tbl[11] = mk(7'h01, 4'h5, 0, 0, 0, 1, 2'd3, 0);
    tbl[12] = mk(7'h00, 4'h5, 0, 1, 0, 0, 2'd3, 0);
    tbl[13] = mk(7'h01, 4'h5, 0, 0, 0, 1, 2'd3, 0);
    tbl[14] = mk(7'h71, 4'hF, 1, 0, 1, 0, 2'd3, 0);
    tbl[15] = mk(7'h3F, 4'h0, 1, 0, 1, 0, 2'd3, 0);
    tbl[16] = mk(7'h77, 4'hA, 1, 0, 1, 0, 2'd3, 0);
    tbl[17] = mk(7'h00, 4'hA, 0, 1, 0, 0, 2'd0, 1);
    tbl[18] = mk(7'h01, 4'hA, 0, 0, 0, 1, 2'd1, 0);
    tbl[19] = mk(7'h00, 4'hA, 0, 1, 0, 0, 2'd1, 0);
    tbl[20] = mk(7'h01, 4'hA, 0, 0, 0, 1, 2'd2, 0);
    tbl[21] = mk(7'h00, 4'hA, 0, 1, 0, 0, 2'd2, 0);
    tbl[22] = mk(7'h01, 4'hA, 0, 0, 0, 1, 2'd0, 1);
    tbl[23] = mk(7'h07, 4'h7, 1, 0, 1, 0, 2'd0, 0);
    repeat (3) tick;
    chk("rst_a", {digit_a, valid_a, blank_a, nd_a, err_a, 6'(ecnt_a)}, 14'd0);
    chk("rst_b", {digit_b, valid_b, blank_b, nd_b, err_b, ecnt_b}, 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 12 && !blank_a; i++) begin
      tick;
      chk("rst_release_pulse", {nd_a, err_a}, 2'b00);
    end
    chk("rst_blank", {digit_a, valid_a, blank_a}, 6'b000001);
    prev = mk(7'h00, 4'h0, 0, 1, 0, 0, 2'd0, 0);
    for (int i = 0; i < 24; i++) apply(tbl[i], $sformatf("vec%0d", i));
    seg_a = ~7'h7F;
    tick;
    tick;
    seg_a = ~7'h07;
    for (int i = 0; i < 14; i++) begin
      tick;
      chk("glitch_hold", {digit_a, valid_a, nd_a, err_a}, {4'h7, 3'b100});
    end
    seg_a = ~7'h5B;
    repeat (4) tick;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("mid_rst", {digit_a, valid_a, blank_a, nd_a, err_a, 6'(ecnt_a)}, 14'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("post_rst", {digit_a, valid_a, blank_a, nd_a, err_a, 6'(ecnt_a)}, 14'd0);
    end
    for (int i = 0; i < 20 && !valid_a; i++) tick;
    chk("relock_after_rst", {digit_a, valid_a}, {4'h2, 1'b1});
    chk("b_idle_blank", {valid_b, blank_b}, 2'b01);
    seg_b = 7'h71;
    repeat (3) tick;
    chk("b_early", {valid_b, blank_b, nd_b}, 3'b010);
    tick;
    chk("b_polarity", {digit_b, valid_b, blank_b, nd_b}, {4'hF, 3'b101});
    tick;
    chk("b_pulse_end", nd_b, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seven_seg_decoder.md
Name: seven_seg_decoder

Overview:
- Receive-side counterpart to the team's hex-to-7-segment display drivers.
- Samples a 7-segment bus (segments a..g), waits until the pattern has been stable for a programmable number of cycles, and decodes it back to a 4-bit hex value.
- Flags blank and illegal patterns, and keeps a saturating count of illegal patterns.
- Used as a loop-back monitor on display outputs and to read segment buses from external boards.

Parameters:
- ACTIVE_LOW, 1, 1 = input segment low means lit (board convention); 0 = high means lit.
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a pattern is accepted; legal range 1..255.
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- seg_in  input  7  segment bus; bit0=a … bit6=g; asynchronous to clk.
- err_clr  input  1  synchronous clear of err_count.
- digit_out  output  4  last accepted hex value.
- digit_valid  output  1  level; high while the locked pattern is a legal digit.
- new_digit  output  1  one-cycle pulse when a legal digit is accepted.
- blank  output  1  level; high while the locked pattern is all segments off.
- err  output  1  one-cycle pulse when an illegal pattern is accepted.
- err_count  output  ERR_W  saturating count of illegal patterns accepted.

Behaviour:
- **Input normalization**
  - seg_in passes through a 2-flop synchronizer.
  - If ACTIVE_LOW=1, the synchronizer output is inverted to lit-high form (pat).
  - Synchronizer flops reset to the "all off" level.
- **Decode table** (lit-high, g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - 00 = blank; any other value = illegal.
- **FSM states:** IDLE, SETTLING, LOCKED; reset enters IDLE.
- **IDLE:** load cand<=pat, cnt<=1, go to SETTLING.
- **SETTLING:**
  - If pat!=cand: cand<=pat, cnt<=1, stay.
  - Else if cnt==STABLE_CYCLES: accept cand and go to LOCKED.
  - Else cnt<=cnt+1.
  - With STABLE_CYCLES=1, accept on the first sample.
- **LOCKED:**
  - If pat!=cand: cand<=pat, cnt<=1, go to SETTLING.
  - Outputs hold their locked values until the next accept.
- **Accept actions** (registered; visible the cycle after the accept edge):
  - Legal digit: digit_out<=value, digit_valid<=1, blank<=0.
    - new_digit pulses if digit_valid was 0 or value differs from the previous digit_out.
    - Re-accepting the same digit after a glitch gives no pulse.
  - Blank: digit_valid<=0, blank<=1, digit_out holds its last value, no pulse.
  - Illegal: digit_valid<=0, blank<=0, digit_out holds, err pulses one cycle, err_count increments.
- **Latency:** a seg_in change held steady is reflected at the outputs exactly 2+STABLE_CYCLES+1 clk edges after the first edge that samples it.
  - With default STABLE_CYCLES=4, that is 7 edges.
- **Glitch rejection:** a pattern held for fewer than STABLE_CYCLES synchronized samples is never accepted; outputs keep their locked values throughout.
- **err_count:**
  - Saturates at 2^ERR_W-1; err still pulses when saturated.
  - err_clr sets it to 0.
  - If err_clr and an illegal accept occur in the same cycle, clear wins (count=0); err still pulses.
- **Reset values:**
  - digit_out=0, digit_valid=0, new_digit=0, blank=0, err=0, err_count=0, cnt=0, cand=00.
- **Reset mid-operation:** aborts any settling; no pulses are emitted during or on the cycle after rst.
- **After reset release with an unlit bus:** blank asserts after the normal latency.

Test Plan:
- **Reset then legal digit:** rst 3 cycles, seg_in=~7'h5B (ACTIVE_LOW=1, STABLE_CYCLES=4) held → 7 edges later digit_out=2, digit_valid=1, new_digit exactly one cycle, blank=0.
- **Glitch rejection:** lock on 7; drive ~7'h7F for 2 cycles, then back to ~7'h07 → digit_out stays 7, no new_digit, no err at any point.
- **Same digit after blank:** lock 5, drive all-off (7'h7F) → blank=1, digit_valid=0, digit_out=5; drive 5 again → new_digit pulses, blank=0.
- **Illegal pattern and saturation:** ERR_W=2; apply pattern 0x01 (a only) then blank, 5 times → 5 err pulses, err_count 1,2,3,3,3, digit_valid=0 while the illegal pattern is locked.
- **Clear priority:** err_count=2; assert err_clr on the illegal-accept cycle → err pulses, err_count=0 the next cycle.
- **Reset mid-settle and polarity:** change seg_in, assert rst 2 cycles into settling → all outputs at reset values, no pulse; with ACTIVE_LOW=0, seg_in=7'h71 → digit_out=F.
